// File: rtl/vga_value_source.sv
// Value feeder for the 8-digit hex VGA display: three debug registers, a cycle counter,
// a debounced source-select button. Define FRAME_SYNC_EN to lock display updates to vs rising edges.
module vga_value_source #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        cpu_halt,
    input  logic        btn_next,
    input  logic        vs,
    output logic [31:0] disp_value,
    output logic [1:0]  disp_sel,
    output logic        update_pulse
);

    logic [31:0]          r_reg0;
    logic [31:0]          r_reg1;
    logic [31:0]          r_reg2;
    logic [31:0]          r_cycleCnt;
    logic                 r_btnS1;
    logic                 r_btnS2;
    logic                 r_btnDeb;
    logic [CNT_WIDTH-1:0] r_debCnt;
    logic [1:0]           r_selPending;
    logic [31:0]          w_source;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg0 <= 32'd0;
            r_reg1 <= 32'd0;
            r_reg2 <= 32'd0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0:    r_reg0 <= wr_data;
                2'd1:    r_reg1 <= wr_data;
                2'd2:    r_reg2 <= wr_data;
                default: ;
            endcase
        end
    end

    // A CPU preload takes priority over the free-running increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycleCnt <= 32'd0;
        end else if (wr_en && (wr_addr == 2'd3)) begin
            r_cycleCnt <= wr_data;
        end else if (!cpu_halt) begin
            r_cycleCnt <= r_cycleCnt + 32'd1;
        end
    end

    // Only a debounced rising edge of the button advances the pending selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btnS1      <= 1'b0;
            r_btnS2      <= 1'b0;
            r_btnDeb     <= 1'b0;
            r_debCnt     <= '0;
            r_selPending <= 2'd0;
        end else begin
            r_btnS1 <= btn_next;
            r_btnS2 <= r_btnS1;
            if (r_btnS2 != r_btnDeb) begin
                if (r_debCnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                    r_btnDeb <= r_btnS2;
                    r_debCnt <= '0;
                    if (r_btnS2) begin
                        r_selPending <= r_selPending + 2'd1;
                    end
                end else begin
                    r_debCnt <= r_debCnt + CNT_WIDTH'(1);
                end
            end else begin
                r_debCnt <= '0;
            end
        end
    end

    always_comb begin
        w_source = r_cycleCnt;
        case (r_selPending)
            2'd0:    w_source = r_reg0;
            2'd1:    w_source = r_reg1;
            2'd2:    w_source = r_reg2;
            default: w_source = r_cycleCnt;
        endcase
    end

`ifdef FRAME_SYNC_EN
    logic r_vsS1;
    logic r_vsS2;
    logic r_vsS3;
    logic w_frameEdge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsS1 <= 1'b0;
            r_vsS2 <= 1'b0;
            r_vsS3 <= 1'b0;
        end else begin
            r_vsS1 <= vs;
            r_vsS2 <= r_vsS1;
            r_vsS3 <= r_vsS2;
        end
    end

    // End of the active-low sync pulse marks the frame boundary.
    assign w_frameEdge = r_vsS2 & ~r_vsS3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_value   <= 32'd0;
            disp_sel     <= 2'd0;
            update_pulse <= 1'b0;
        end else if (w_frameEdge) begin
            disp_value   <= w_source;
            disp_sel     <= r_selPending;
            update_pulse <= 1'b1;
        end else begin
            update_pulse <= 1'b0;
        end
    end
`else
    logic w_unusedVs;
    assign w_unusedVs = vs;

    // Without frame locking the display follows the source every cycle and flags real changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_value   <= 32'd0;
            disp_sel     <= 2'd0;
            update_pulse <= 1'b0;
        end else begin
            disp_value   <= w_source;
            disp_sel     <= r_selPending;
            update_pulse <= (w_source != disp_value) || (r_selPending != disp_sel);
        end
    end
`endif

endmodule
